// File: rtl/sh7604_ext_bus_bridge.sv
// sh7604_ext_bus_bridge
//   Bridges SH7604 CS0..3_N external bus cycles onto a single-request memory
//   handshake. Drives WAIT_N and read data back to the CPU. Enforces a
//   programmable WAIT_N floor (MIN_WAIT) and a bus-timeout watchdog (TIMEOUT).
//   Optional feature macro: SH7604_BRIDGE_POST_WR_EN
//   (posted writes through a one-entry buffer).
module sh7604_ext_bus_bridge #(
  parameter int unsigned MIN_WAIT = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [3:0]  CS_MASK  = 4'hF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [26:0] A,
  input  logic [31:0] DO,
  input  logic        BS_N,
  input  logic [3:0]  CS_N,
  input  logic        RD_WR_N,
  input  logic [3:0]  WE_N,
  output logic [31:0] DI,
  output logic        WAIT_N,
  output logic [26:0] MEM_A,
  output logic [1:0]  MEM_CS,
  output logic [31:0] MEM_DO,
  output logic [3:0]  MEM_BE,
  output logic        MEM_WR,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DI,
  output logic        TO_FLAG
);

  localparam logic [3:0] MIN_WAIT_C = 4'(MIN_WAIT);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_PEND,
    S_HOLD,
    S_END
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] di_q, di_d;
  logic        wait_n_q, wait_n_d;
  logic [26:0] mem_a_q, mem_a_d;
  logic [1:0]  mem_cs_q, mem_cs_d;
  logic [31:0] mem_do_q, mem_do_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_req_q, mem_req_d;
  logic        to_flag_q, to_flag_d;
  logic [3:0]  wc_q, wc_d;
  logic [7:0]  tc_q, tc_d;

`ifdef SH7604_BRIDGE_POST_WR_EN
  // CPU-side capture of the accepted access; moved into MEM_* once the
  // posted-write buffer (the MEM_* registers themselves) is free.
  logic [26:0] acc_a_q, acc_a_d;
  logic [1:0]  acc_cs_q, acc_cs_d;
  logic [31:0] acc_do_q, acc_do_d;
  logic [3:0]  acc_be_q, acc_be_d;
  logic        acc_wr_q, acc_wr_d;
  logic        posted_q, posted_d;
`endif

  logic [3:0] cs_hit;
  logic [1:0] cs_idx;
  logic       accept;
  logic       ack_fire;
  logic [3:0] wc_inc;
  logic [7:0] tc_inc;

  // Served chip-select decode with lowest-index priority and start detect
  always_comb begin
    cs_hit = ~CS_N & CS_MASK;
    cs_idx = 2'd3;
    if (cs_hit[0])      cs_idx = 2'd0;
    else if (cs_hit[1]) cs_idx = 2'd1;
    else if (cs_hit[2]) cs_idx = 2'd2;
    accept = CE_R && !BS_N && (cs_hit != 4'h0);
    wc_inc = (wc_q == 4'hF) ? wc_q : wc_q + 4'd1;
    tc_inc = (tc_q == 8'hFF) ? tc_q : tc_q + 8'd1;
`ifdef SH7604_BRIDGE_POST_WR_EN
    ack_fire = MEM_ACK && mem_req_q && ((state_q == S_PEND) || posted_q);
`else
    ack_fire = MEM_ACK && mem_req_q && (state_q == S_PEND);
`endif
  end

  // Next-state and registered-output computation for the bus FSM
  always_comb begin
    state_d   = state_q;
    di_d      = di_q;
    wait_n_d  = wait_n_q;
    mem_a_d   = mem_a_q;
    mem_cs_d  = mem_cs_q;
    mem_do_d  = mem_do_q;
    mem_be_d  = mem_be_q;
    mem_wr_d  = mem_wr_q;
    mem_req_d = mem_req_q;
    to_flag_d = to_flag_q;
    wc_d      = wc_q;
    tc_d      = tc_q;
`ifdef SH7604_BRIDGE_POST_WR_EN
    acc_a_d   = acc_a_q;
    acc_cs_d  = acc_cs_q;
    acc_do_d  = acc_do_q;
    acc_be_d  = acc_be_q;
    acc_wr_d  = acc_wr_q;
    posted_d  = posted_q;
`endif

    unique case (state_q)
      S_IDLE, S_END: begin
        if (accept) begin
`ifdef SH7604_BRIDGE_POST_WR_EN
          acc_a_d  = A;
          acc_cs_d = cs_idx;
          acc_do_d = DO;
          acc_be_d = RD_WR_N ? 4'hF : ~WE_N;
          acc_wr_d = !RD_WR_N;
`else
          mem_a_d  = A;
          mem_cs_d = cs_idx;
          mem_do_d = DO;
          mem_be_d = RD_WR_N ? 4'hF : ~WE_N;
          mem_wr_d = !RD_WR_N;
`endif
          wait_n_d = 1'b0;
          state_d  = S_ISSUE;
        end else if ((state_q == S_END) && CE_R && (CS_N == 4'hF)) begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
`ifdef SH7604_BRIDGE_POST_WR_EN
        // Stall here (WAIT_N still low) while a posted write drains.
        if (!mem_req_q) begin
          mem_a_d   = acc_a_q;
          mem_cs_d  = acc_cs_q;
          mem_do_d  = acc_do_q;
          mem_be_d  = acc_be_q;
          mem_wr_d  = acc_wr_q;
          mem_req_d = 1'b1;
          wc_d      = '0;
          tc_d      = '0;
          if (acc_wr_q) begin
            posted_d = 1'b1;
            state_d  = S_HOLD;
          end else begin
            state_d  = S_PEND;
          end
        end
`else
        mem_req_d = 1'b1;
        wc_d      = '0;
        tc_d      = '0;
        state_d   = S_PEND;
`endif
      end

      S_PEND: begin
        if (CE_R) begin
          wc_d = wc_inc;
          tc_d = tc_inc;
        end
        // Ack has priority over a timeout landing in the same clock.
        if (ack_fire) begin
          mem_req_d = 1'b0;
          if (!mem_wr_q) di_d = MEM_DI;
          state_d = S_HOLD;
        end else if (CE_R && (tc_inc == TIMEOUT_C)) begin
          mem_req_d = 1'b0;
          di_d      = 32'hFFFF_FFFF;
          to_flag_d = 1'b1;
          state_d   = S_HOLD;
        end
      end

      S_HOLD: begin
        // The floor counts the current CE_R, so an immediate ack with
        // MIN_WAIT=N yields N+1 low WAIT_N samples.
        if (CE_R) begin
          wc_d = wc_inc;
          if (wc_inc >= MIN_WAIT_C) begin
            wait_n_d = 1'b1;
            state_d  = S_END;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef SH7604_BRIDGE_POST_WR_EN
    // Background drain of a posted write, with its own watchdog.
    if (posted_q && mem_req_q) begin
      if (CE_R) tc_d = tc_inc;
      if (MEM_ACK) begin
        mem_req_d = 1'b0;
        posted_d  = 1'b0;
      end else if (CE_R && (tc_inc == TIMEOUT_C)) begin
        mem_req_d = 1'b0;
        posted_d  = 1'b0;
        to_flag_d = 1'b1;
      end
    end
`endif
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      di_q      <= '0;
      wait_n_q  <= 1'b1;
      mem_a_q   <= '0;
      mem_cs_q  <= '0;
      mem_do_q  <= '0;
      mem_be_q  <= '0;
      mem_wr_q  <= 1'b0;
      mem_req_q <= 1'b0;
      to_flag_q <= 1'b0;
      wc_q      <= '0;
      tc_q      <= '0;
`ifdef SH7604_BRIDGE_POST_WR_EN
      acc_a_q   <= '0;
      acc_cs_q  <= '0;
      acc_do_q  <= '0;
      acc_be_q  <= '0;
      acc_wr_q  <= 1'b0;
      posted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      di_q      <= di_d;
      wait_n_q  <= wait_n_d;
      mem_a_q   <= mem_a_d;
      mem_cs_q  <= mem_cs_d;
      mem_do_q  <= mem_do_d;
      mem_be_q  <= mem_be_d;
      mem_wr_q  <= mem_wr_d;
      mem_req_q <= mem_req_d;
      to_flag_q <= to_flag_d;
      wc_q      <= wc_d;
      tc_q      <= tc_d;
`ifdef SH7604_BRIDGE_POST_WR_EN
      acc_a_q   <= acc_a_d;
      acc_cs_q  <= acc_cs_d;
      acc_do_q  <= acc_do_d;
      acc_be_q  <= acc_be_d;
      acc_wr_q  <= acc_wr_d;
      posted_q  <= posted_d;
`endif
    end
  end

  assign DI      = di_q;
  assign WAIT_N  = wait_n_q;
  assign MEM_A   = mem_a_q;
  assign MEM_CS  = mem_cs_q;
  assign MEM_DO  = mem_do_q;
  assign MEM_BE  = mem_be_q;
  assign MEM_WR  = mem_wr_q;
  assign MEM_REQ = mem_req_q;
  assign TO_FLAG = to_flag_q;

endmodule
